// File: rtl/v8cpu_alu_seq_if.sv
// Request/result bundle for v8cpu_alu_seq: request handshake, operands, result handshake and status.
// master = requester/consumer side, slave = ALU side.
interface v8cpu_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic [7:0]       newFlags;
    logic             busy;

    modport master (
        output in_valid, op, a, b, flags, out_ready,
        input  in_ready, out_valid, c, newFlags, busy
    );

    modport slave (
        input  in_valid, op, a, b, flags, out_ready,
        output in_ready, out_valid, c, newFlags, busy
    );
endinterface

// File: rtl/v8cpu_alu_seq.sv
// Sequential ALU; MUL (shift-add) and DIV/MOD (restoring) exist only with V8CPU_ALU_MULDIV_EN defined.
// Latency: result 1 cycle after accept, WIDTH+1 cycles for MUL/DIV/MOD.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE and never while rst is high.
module v8cpu_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    v8cpu_alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] cReg;
    logic [7:0]       flagsReg;
    logic             accept;
    logic             isMulDiv;
    logic             lastStep;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] scC;
    logic             scCarry, scOvf;
    logic             unusedBits;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.c         = cReg;
    assign bus.newFlags  = flagsReg;
    assign accept        = bus.in_valid && bus.in_ready;

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    // Single-cycle results; unlisted opcodes fall out as c=0 so Z=1, C=N=V=0.
    always_comb begin
        scC     = '0;
        scCarry = 1'b0;
        scOvf   = 1'b0;
        case (bus.op)
            4'd0: begin
                scC     = sum[WIDTH-1:0];
                scCarry = sum[WIDTH];
                scOvf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                scC     = diff[WIDTH-1:0];
                scCarry = diff[WIDTH];
                scOvf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: scC = bus.a & bus.b;
            4'd3: scC = bus.a | bus.b;
            4'd4: scC = bus.a ^ bus.b;
            4'd5: begin
                scC     = {bus.a[WIDTH-2:0], 1'b0};
                scCarry = bus.a[WIDTH-1];
            end
            4'd6: begin
                scC     = {1'b0, bus.a[WIDTH-1:1]};
                scCarry = bus.a[0];
            end
            default: ;
        endcase
    end

`ifdef V8CPU_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    logic [3:0]         opReg;
    logic [WIDTH-1:0]   aReg, bReg;
    logic [3:0]         hiFlags;
    logic [2*WIDTH-1:0] p, pStep;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mulSum, divShift, divRem;
    logic               divFits, bZero;
    logic [WIDTH-1:0]   mdC;
    logic               mdCarry;

    assign isMulDiv = (bus.op == 4'd7) || (bus.op == 4'd8) || (bus.op == 4'd9);
    assign lastStep = (cnt == '0);
    assign bZero    = (bReg == '0);

    // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV/MOD.
    assign mulSum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, aReg & {WIDTH{p[0]}}};
    assign divShift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, bReg};
    assign divRem   = divFits ? divShift - {1'b0, bReg} : divShift;

    always_comb begin
        pStep = {divRem[WIDTH-1:0], p[WIDTH-2:0], divFits};
        if (opReg == 4'd7) begin
            pStep = {mulSum, p[WIDTH-1:1]};
        end
    end

    always_comb begin
        mdC     = pStep[WIDTH-1:0];
        mdCarry = 1'b0;
        case (opReg)
            4'd7: mdCarry = |pStep[2*WIDTH-1:WIDTH];
            4'd8: begin
                mdCarry = bZero;
                if (bZero) mdC = '1;
            end
            default: begin
                mdCarry = bZero;
                mdC     = bZero ? aReg : pStep[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && isMulDiv) begin
            opReg   <= bus.op;
            aReg    <= bus.a;
            bReg    <= bus.b;
            hiFlags <= bus.flags[7:4];
            cnt     <= CW'(WIDTH - 1);
            p       <= {{WIDTH{1'b0}}, (bus.op == 4'd7) ? bus.b : bus.a};
        end else if (state == BUSY) begin
            p   <= pStep;
            cnt <= cnt - CW'(1);
        end
    end

    assign unusedBits = ^{bus.flags[3:0], divRem[WIDTH]};
`else
    assign isMulDiv   = 1'b0;
    assign lastStep   = 1'b0;
    assign unusedBits = ^bus.flags[3:0];
`endif

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = isMulDiv ? BUSY : DONE;
            BUSY:    if (lastStep) stateNext = DONE;
            DONE:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cReg     <= '0;
            flagsReg <= '0;
        end else begin
            state <= stateNext;
            if (accept && !isMulDiv) begin
                cReg     <= scC;
                flagsReg <= {bus.flags[7:4], scOvf, scC[WIDTH-1], scCarry, scC == '0};
            end
`ifdef V8CPU_ALU_MULDIV_EN
            if (state == BUSY && lastStep) begin
                cReg     <= mdC;
                flagsReg <= {hiFlags, (opReg == 4'd7) && mdCarry, mdC[WIDTH-1], mdCarry, mdC == '0};
            end
`endif
        end
    end
endmodule

// File: doc/v8cpu_alu_seq.md
V8CPU_ALU_SEQ -- requirements
Module: v8cpu_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: op  input  4  opcode.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands.
REQ-008 SHALL have port: flags  input  8  current flag register.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: c  output  WIDTH  result.
REQ-012 SHALL have port: newFlags  output  8  updated flags. Bit 0 = Z, bit 1 = C, bit 2 = N, bit 3 = V, bits 7:4 = flags[7:4] latched at accept.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE. in_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on in_valid & in_ready and latch op, a, b and flags. Later input changes SHALL have no effect.
REQ-016 Single-cycle ops SHALL go IDLE->DONE, with out_valid high in the cycle after accept.
REQ-017 MUL/DIV SHALL go IDLE->BUSY for exactly WIDTH cycles, then DONE, with out_valid high WIDTH+1 cycles after accept.
REQ-018 In DONE, c, newFlags and out_valid=1 SHALL hold stable until out_ready=1. That handshake cycle SHALL return the FSM to IDLE. The next accept is possible one cycle later.
REQ-019 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR (logical) by 1, 7 MUL (unsigned, low WIDTH bits), 8 DIV (unsigned quotient), 9 MOD (unsigned remainder).
REQ-020 Opcodes 10-15 SHALL be single-cycle with c=0 and Z=1, C=N=V=0.
REQ-021 For all ops, Z=(c==0) and N=c[WIDTH-1] (except REQ-020).
REQ-022 ADD: C = carry out; V = signed overflow.
REQ-023 SUB: C = borrow (a<b unsigned); V = signed overflow.
REQ-024 AND/OR/XOR: C=0, V=0.
REQ-025 SHL: C = a[WIDTH-1]. SHR: C = a[0]. Both: V=0.
REQ-026 MUL: shift-add, one bit per cycle. C = V = 1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero.
REQ-027 DIV/MOD: restoring division, one quotient bit per cycle. V=0.
REQ-028 DIV/MOD with b=0: SHALL still take WIDTH cycles. DIV gives c = all ones; MOD gives c = a. C=1 in both cases.
REQ-029 DIV/MOD with b!=0: C=0.

Reset
REQ-030 rst=1 SHALL force IDLE, c=0, newFlags=0, out_valid=0, busy=0 and in_ready=0 on the next edge, aborting any BUSY/DONE operation without output.
REQ-031 in_ready SHALL be 0 while rst=1, and 1 from the first cycle after rst deasserts.
REQ-032 A request presented during reset SHALL NOT be accepted.

Configuration
REQ-033 Macro V8CPU_ALU_MULDIV_EN defined: ops 7-9 SHALL behave per REQ-026..029.
REQ-034 Macro V8CPU_ALU_MULDIV_EN undefined: ops 7-9 SHALL be treated as REQ-020 opcodes (single-cycle, c=0, Z=1), and the BUSY datapath (multiplier/divider registers) SHALL be absent.

Verification (WIDTH=8, MULDIV_EN defined)
REQ-035 ADD a=12, b=24 -> c=36, Z=0, C=0, out_valid 1 cycle after accept. ADD a=200, b=100 -> c=44, C=1, V=0.
REQ-036 SUB a=50, b=50 -> c=0, Z=1, C=0. SUB a=45, b=23 -> c=22. SUB a=23, b=45 -> c=234, C=1, N=1.
REQ-037 MUL a=15, b=17 -> c=255, C=0, out_valid exactly 9 cycles after accept. MUL a=16, b=16 -> c=0, Z=1, C=1.
REQ-038 DIV a=100, b=7 -> c=14. MOD a=100, b=7 -> c=2. DIV a=75, b=0 -> c=255, C=1. MOD a=75, b=0 -> c=75, C=1.
REQ-039 out_ready=0 for 5 cycles after an XOR a=0xF0, b=0xFF result -> c=0x0F held stable, in_ready=0 throughout. An in_valid request presented meanwhile is accepted only after the handshake.
REQ-040 rst pulsed during cycle 4 of a MUL -> no out_valid, all outputs 0. A fresh ADD a=1, b=1 after reset -> c=2.
